wmem_ctrl: RTL and testbench

- Sequencer for the PE-array weight memory, sitting between the host weight stream and the memory's write and read ports.
- LOAD phase: accepts weight rows over a valid/ready stream and writes them to consecutive addresses from 0.
- RUN phase: replays the stored rows to the PE array, in address order, for a configured number of passes, with backpressure from the array.
- Weights are retained after a run, so the same set can be run again without reloading.

---
 rtl/wmem_pkg.sv | 13 +
 rtl/wmem_ctrl_if.sv | 29 ++
 rtl/wmem_rd_seq.sv | 36 +++
 rtl/wmem_ctrl.sv | 87 ++++++++
 tb/tb_wmem_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/wmem_pkg.sv
// wmem_pkg: shared weight-memory constants and controller state encoding
package wmem_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ROW_NUM    = 6;
   localparam int DEF_ADDR_WIDTH = 7;
   localparam int DEF_PASS_WIDTH = 8;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2,
      RUN   = 2'd3
   } state_e;
endpackage

// File: rtl/wmem_ctrl_if.sv
// wmem_ctrl_if: host weight stream, memory write port and PE-side read port
//   master: controller side (drives o_*), slave: host/memory/PE side (drives i_*)
interface wmem_ctrl_if
   import wmem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ROW_NUM    = DEF_ROW_NUM,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   localparam int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM;
   logic                     i_wgt_valid;
   logic [ROW_WGT_WIDTH-1:0] i_wgt_data;
   logic                     o_wgt_ready;
   logic                     o_wr_en;
   logic [ADDR_WIDTH-1:0]    o_wr_addr;
   logic [ROW_WGT_WIDTH-1:0] o_wr_data;
   logic                     i_pe_ready;
   logic                     o_rd_en;
   logic [ADDR_WIDTH-1:0]    o_rd_addr;
   logic                     o_rd_last;
   modport master (
      input  i_wgt_valid, i_wgt_data, i_pe_ready,
      output o_wgt_ready, o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr, o_rd_last
   );
   modport slave (
      output i_wgt_valid, i_wgt_data, i_pe_ready,
      input  o_wgt_ready, o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr, o_rd_last
   );
endinterface

// File: rtl/wmem_rd_seq.sv
// wmem_rd_seq: replay address / pass counter pair with wrap and final-read detection
//   i_advance: a read issues this cycle; i_rows/i_passes: run geometry; i_clear: zero counters
//   o_addr: current read row; o_last: this read is the final row of the final pass
module wmem_rd_seq #(
   parameter int ADDR_WIDTH = 7,
   parameter int PASS_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   input  logic                  i_advance,
   input  logic [ADDR_WIDTH-1:0] i_rows,
   input  logic [PASS_WIDTH-1:0] i_passes,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last
);
   logic [ADDR_WIDTH-1:0] rd_cnt_q;
   logic [PASS_WIDTH-1:0] pass_cnt_q;
   logic                  row_end;
   assign row_end = rd_cnt_q == i_rows - ADDR_WIDTH'(1);
   assign o_last  = i_advance && row_end && pass_cnt_q == i_passes - PASS_WIDTH'(1);
   assign o_addr  = rd_cnt_q;
   // Counters return to zero on the final read so the next run starts clean
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_cnt_q   <= '0;
         pass_cnt_q <= '0;
      end else if (i_clear || o_last) begin
         rd_cnt_q   <= '0;
         pass_cnt_q <= '0;
      end else if (i_advance) begin
         rd_cnt_q   <= row_end ? '0 : rd_cnt_q + ADDR_WIDTH'(1);
         pass_cnt_q <= row_end ? pass_cnt_q + PASS_WIDTH'(1) : pass_cnt_q;
      end
   end
endmodule

// File: rtl/wmem_ctrl.sv
// wmem_ctrl: weight-memory sequencer, loads host rows then replays them to the PE array
//   i_load_start/i_run_start: start pulses; i_clear: sync abort; i_cfg_*: geometry
//   o_loaded/o_busy: status levels; o_done/o_cfg_err: one-cycle pulses; bus: stream/memory ports
module wmem_ctrl
   import wmem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ROW_NUM    = DEF_ROW_NUM,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int PASS_WIDTH = DEF_PASS_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load_start,
   input  logic                  i_run_start,
   input  logic                  i_clear,
   input  logic [ADDR_WIDTH-1:0] i_cfg_rows,
   input  logic [PASS_WIDTH-1:0] i_cfg_passes,
   output logic                  o_loaded,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_cfg_err,
   wmem_ctrl_if.master           bus
);
   localparam int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM;
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rows_q, wr_cnt_q;
   logic [PASS_WIDTH-1:0] passes_q;
   logic                  loaded_q, done_q, cfg_err_q;
   logic                  idle_rdy, load_req, load_go, run_req, run_go;
   logic                  wr_hs, wr_last, rd_last;
   assign idle_rdy = state_q == IDLE || state_q == READY;
   assign load_req = idle_rdy && i_load_start;
   assign load_go  = load_req && i_cfg_rows != '0;
   // A simultaneous load start takes precedence over a run start
   assign run_req  = idle_rdy && !i_load_start && i_run_start;
   assign run_go   = run_req && state_q == READY && i_cfg_passes != '0;
   // Gating with i_clear suppresses the handshake in the abort cycle
   assign bus.o_wgt_ready = state_q == LOAD && !i_clear;
   assign wr_hs           = bus.o_wgt_ready && bus.i_wgt_valid;
   assign wr_last         = wr_hs && wr_cnt_q == rows_q - ADDR_WIDTH'(1);
   assign bus.o_wr_en     = wr_hs;
   assign bus.o_wr_addr   = wr_cnt_q;
   assign bus.o_wr_data   = ROW_WGT_WIDTH'(bus.i_wgt_data);
   assign bus.o_rd_en     = state_q == RUN && !i_clear && bus.i_pe_ready;
   assign bus.o_rd_last   = rd_last;
   assign o_loaded  = loaded_q;
   assign o_busy    = state_q == LOAD || state_q == RUN;
   assign o_done    = done_q;
   assign o_cfg_err = cfg_err_q;
   wmem_rd_seq #(.ADDR_WIDTH(ADDR_WIDTH), .PASS_WIDTH(PASS_WIDTH)) u_rd_seq (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (i_clear),
      .i_advance (bus.o_rd_en),
      .i_rows    (rows_q),
      .i_passes  (passes_q),
      .o_addr    (bus.o_rd_addr),
      .o_last    (rd_last)
   );
   always_comb begin
      state_d = i_clear ? IDLE  :
                load_go ? LOAD  :
                run_go  ? RUN   :
                wr_last ? READY :
                rd_last ? READY : state_q;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         rows_q    <= '0;
         passes_q  <= '0;
         wr_cnt_q  <= '0;
         loaded_q  <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_err_q <= !i_clear && ((load_req && i_cfg_rows == '0) || (run_req && !run_go));
         done_q    <= !i_clear && rd_last;
         wr_cnt_q  <= (i_clear || load_go) ? '0 : wr_hs ? wr_cnt_q + ADDR_WIDTH'(1) : wr_cnt_q;
         loaded_q  <= !(i_clear || load_go) && (loaded_q || wr_last);
         if (load_go) rows_q <= i_cfg_rows;
         if (run_go) passes_q <= i_cfg_passes;
      end
   end
endmodule

// File: tb/tb_wmem_ctrl.sv
// tb_wmem_ctrl: directed self-checking bench for wmem_ctrl
module tb_wmem_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, load_start, run_start, clear;
   logic [6:0] cfg_rows;
   logic [7:0] cfg_passes;
   logic       loaded, busy, done, cfg_err;
   int         checks = 0;
   int         failures = 0;
   int         exp_addr, reads, stall, cyc;
   logic       pe;
   always #5 clk = ~clk;
   wmem_ctrl_if bus();
   wmem_ctrl dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_load_start (load_start),
      .i_run_start  (run_start),
      .i_clear      (clear),
      .i_cfg_rows   (cfg_rows),
      .i_cfg_passes (cfg_passes),
      .o_loaded     (loaded),
      .o_busy       (busy),
      .o_done       (done),
      .o_cfg_err    (cfg_err),
      .bus          (bus)
   );
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      rst_n = 1'b0; load_start = 1'b0; run_start = 1'b0; clear = 1'b0;
      cfg_rows = '0; cfg_passes = '0;
      bus.i_wgt_valid = 1'b0; bus.i_wgt_data = '0; bus.i_pe_ready = 1'b0;
      #12;
      chk("rst_ready", bus.o_wgt_ready, 0);
      chk("rst_wr_en", bus.o_wr_en, 0);
      chk("rst_rd_en", bus.o_rd_en, 0);
      chk("rst_rd_last", bus.o_rd_last, 0);
      chk("rst_loaded", loaded, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      // basic load of four rows
      cfg_rows = 7'd4; load_start = 1'b1;
      tick();
      load_start = 1'b0; cfg_rows = '0;
      #1;
      chk("ld_busy", busy, 1);
      chk("ld_loaded", loaded, 0);
      for (int i = 0; i < 4; i++) begin
         bus.i_wgt_valid = 1'b1;
         bus.i_wgt_data  = 48'h11 * (i + 1);
         #1;
         chk("ld_wr_en", bus.o_wr_en, 1);
         chk("ld_wr_addr", bus.o_wr_addr, i);
         chk("ld_wr_data", bus.o_wr_data, 48'h11 * (i + 1));
         tick();
      end
      bus.i_wgt_valid = 1'b0;
      #1;
      chk("ld_loaded_set", loaded, 1);
      chk("ld_ready_busy", busy, 0);
      chk("ld_ready_off", bus.o_wgt_ready, 0);
      // reload with throttled host; load and run start together, load wins
      cfg_rows = 7'd4; cfg_passes = 8'd2; load_start = 1'b1; run_start = 1'b1;
      tick();
      load_start = 1'b0; run_start = 1'b0;
      #1;
      chk("ld_wins", bus.o_wgt_ready, 1);
      chk("reld_loaded_clr", loaded, 0);
      exp_addr = 0;
      for (int c = 0; c < 8; c++) begin
         bus.i_wgt_valid = (c % 2) == 0;
         bus.i_wgt_data  = 48'hA0 + c;
         #1;
         chk("thr_wr_en", bus.o_wr_en, bus.i_wgt_valid);
         chk("thr_wr_addr", bus.o_wr_addr, exp_addr);
         if (bus.i_wgt_valid) exp_addr++;
         tick();
      end
      bus.i_wgt_valid = 1'b0;
      #1;
      chk("thr_loaded", loaded, 1);
      // basic run: 4 rows x 2 passes
      cfg_passes = 8'd2; run_start = 1'b1; bus.i_pe_ready = 1'b1;
      tick();
      run_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("run_rd_en", bus.o_rd_en, 1);
         chk("run_rd_addr", bus.o_rd_addr, i % 4);
         chk("run_rd_last", bus.o_rd_last, i == 7);
         chk("run_no_done", done, 0);
         tick();
      end
      #1;
      chk("run_done", done, 1);
      chk("run_busy", busy, 0);
      chk("run_loaded", loaded, 1);
      chk("run_rd_idle", bus.o_rd_en, 0);
      tick();
      #1;
      chk("run_done_pulse", done, 0);
      // run with a three-cycle PE stall after the third read
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      reads = 0; stall = 0; cyc = 0;
      while (reads < 8 && cyc < 30) begin
         pe = !(reads == 3 && stall < 3);
         bus.i_pe_ready = pe;
         if (!pe) stall++;
         #1;
         chk("bp_rd_en", bus.o_rd_en, pe);
         chk("bp_rd_addr", bus.o_rd_addr, reads % 4);
         chk("bp_rd_last", bus.o_rd_last, pe && reads == 7);
         if (pe) reads++;
         cyc++;
         tick();
      end
      chk("bp_reads", reads, 8);
      chk("bp_cycles", cyc, 11);
      bus.i_pe_ready = 1'b1;
      #1;
      chk("bp_done", done, 1);
      // illegal starts while READY
      cfg_rows = '0; load_start = 1'b1;
      tick();
      load_start = 1'b0;
      #1;
      chk("ill_rows_err", cfg_err, 1);
      chk("ill_rows_busy", busy, 0);
      chk("ill_rows_loaded", loaded, 1);
      chk("ill_rows_wr", bus.o_wr_en, 0);
      tick();
      #1;
      chk("ill_err_pulse", cfg_err, 0);
      cfg_passes = '0; run_start = 1'b1;
      tick();
      run_start = 1'b0;
      #1;
      chk("ill_pass_err", cfg_err, 1);
      chk("ill_pass_rd", bus.o_rd_en, 0);
      chk("ill_pass_busy", busy, 0);
      // abort during the fifth read
      cfg_passes = 8'd2; run_start = 1'b1;
      tick();
      run_start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      clear = 1'b1;
      #1;
      chk("clr_rd_en", bus.o_rd_en, 0);
      tick();
      clear = 1'b0;
      #1;
      chk("clr_busy", busy, 0);
      chk("clr_loaded", loaded, 0);
      chk("clr_done", done, 0);
      chk("clr_rd_idle", bus.o_rd_en, 0);
      tick();
      #1;
      chk("clr_done_late", done, 0);
      // run start in IDLE
      cfg_passes = 8'd2; run_start = 1'b1;
      tick();
      run_start = 1'b0;
      #1;
      chk("idle_run_err", cfg_err, 1);
      chk("idle_run_busy", busy, 0);
      chk("idle_run_rd", bus.o_rd_en, 0);
      // asynchronous reset in the middle of a load
      cfg_rows = 7'd4; load_start = 1'b1;
      tick();
      load_start = 1'b0; bus.i_wgt_valid = 1'b1;
      tick();
      tick();
      #1;
      chk("arst_pre_addr", bus.o_wr_addr, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", bus.o_wgt_ready, 0);
      chk("arst_wr_en", bus.o_wr_en, 0);
      chk("arst_wr_addr", bus.o_wr_addr, 0);
      chk("arst_busy", busy, 0);
      chk("arst_loaded", loaded, 0);
      chk("arst_rd_en", bus.o_rd_en, 0);
      bus.i_wgt_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
